// File: rtl/rf_pkg.sv
// Shared constants and types for the writeback register file.
package rf_pkg;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 4;
  localparam int NUM_REGS  = 2 ** ADDR_W;
  localparam int ZERO_ADDR = 0;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/rf_core.sv
// Register storage: one synchronous write port, two combinational read
// ports, and a synchronous clear of every entry on reset.
module rf_core #(
  parameter int DATA_W = rf_pkg::DATA_W,
  parameter int ADDR_W = rf_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NUM_REGS];

  // Clear all entries on reset, otherwise commit the write port.
  // NOTE: the array is reset because software may read registers it never
  // wrote; this forces flops rather than a RAM macro, which is fine at 16 x 32.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = regs[raddr1];
  assign rdata2 = regs[raddr2];

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: selects load data or ALU result, commits it to the
// architectural register file, serves the two decode read ports and counts
// retired writes.
// Optional macro RF_BYPASS_EN: when defined, a write in flight is forwarded
// to a read port addressing the same register in the same cycle.
module wb_regfile
  import rf_pkg::*;
#(
  parameter int DATA_W  = rf_pkg::DATA_W,
  parameter int ADDR_W  = rf_pkg::ADDR_W,
  parameter int ZERO_R0 = 1,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MReg,
  input  logic              EnRW,
  input  logic [DATA_W-1:0] read_data,
  input  logic [DATA_W-1:0] ALU_out,
  input  logic [ADDR_W-1:0] reg_rd,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_commit,
  output logic [CNT_W-1:0]  wr_count
);

  localparam logic [ADDR_W-1:0] R0 = ADDR_W'(ZERO_ADDR);
  localparam logic HARD_ZERO = (ZERO_R0 != 0);

  logic              wr_eff;
  logic [DATA_W-1:0] raw1;
  logic [DATA_W-1:0] raw2;

  assign wb_data = MReg ? read_data : ALU_out;
  assign wr_eff  = EnRW && !(HARD_ZERO && (reg_rd == R0));

  rf_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .we     (wr_eff),
    .waddr  (reg_rd),
    .wdata  (wb_data),
    .raddr1 (rs1_addr),
    .raddr2 (rs2_addr),
    .rdata1 (raw1),
    .rdata2 (raw2)
  );

  // Read-port shaping: hard-wired zero for R0, then optional write-through.
  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    rs1_data = raw1;
    rs2_data = raw2;
    if (HARD_ZERO && (rs1_addr == R0)) rs1_data = '0;
    if (HARD_ZERO && (rs2_addr == R0)) rs2_data = '0;
`ifdef RF_BYPASS_EN
    // wr_eff already excludes R0 when it is hard-wired, so no extra guard.
    if (wr_eff && (reg_rd == rs1_addr)) rs1_data = wb_data;
    if (wr_eff && (reg_rd == rs2_addr)) rs2_data = wb_data;
`endif
  end

  // Retirement tracking: one-cycle commit pulse and a wrapping write counter.
  // NOTE: sequential state uses non-blocking assignments so all flops update
  // from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_commit <= 1'b0;
      wr_count  <= '0;
    end else begin
      wb_commit <= wr_eff;
      if (wr_eff) wr_count <= wr_count + 1'b1;
    end
  end

  // An unknown write enable outside reset would corrupt state silently.
  always_ff @(posedge clk) begin
    if (!rst) assert (!$isunknown(EnRW));
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile (CNT_W reduced to 4 so the
// counter wrap is reachable). Expectations follow RF_BYPASS_EN if defined.
module tb_wb_regfile;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic          MReg;
  logic          EnRW;
  logic [DW-1:0] read_data;
  logic [DW-1:0] ALU_out;
  logic [AW-1:0] reg_rd;
  logic [AW-1:0] rs1_addr;
  logic [AW-1:0] rs2_addr;
  logic [DW-1:0] rs1_data;
  logic [DW-1:0] rs2_data;
  logic [DW-1:0] wb_data;
  logic          wb_commit;
  logic [CW-1:0] wr_count;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_regs [16];
  logic [CW-1:0] exp_cnt;

  wb_regfile #(
    .DATA_W  (DW),
    .ADDR_W  (AW),
    .ZERO_R0 (1),
    .CNT_W   (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .MReg      (MReg),
    .EnRW      (EnRW),
    .read_data (read_data),
    .ALU_out   (ALU_out),
    .reg_rd    (reg_rd),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .wb_data   (wb_data),
    .wb_commit (wb_commit),
    .wr_count  (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a write; the unselected mux input carries the inverse value.
  task automatic drive_write(input logic [AW-1:0] rd, input logic [DW-1:0] d,
                             input logic sel);
    MReg      = sel;
    read_data = sel ? d : ~d;
    ALU_out   = sel ? ~d : d;
    reg_rd    = rd;
    EnRW      = 1'b1;
  endtask

  task automatic model_write(input logic [AW-1:0] rd, input logic [DW-1:0] d);
    if (rd != 0) begin
      exp_regs[rd] = d;
      exp_cnt      = exp_cnt + 1'b1;
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) exp_regs[i] = '0;
    exp_cnt = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    model_clear();
    rs1_addr = 4'd5;
    #1;
    checks++;
    if (rs1_data !== 32'h0) begin
      errors++; $display("FAIL reset_r5_initial got %h want %h", rs1_data, 32'h0);
    end
    checks++;
    if (wr_count !== 4'd0 || wb_commit !== 1'b0) begin
      errors++; $display("FAIL reset_counters got cnt=%0d commit=%b want 0/0", wr_count, wb_commit);
    end
    drive_write(4'd5, 32'h1234, 1'b0);
    tick();
    EnRW = 1'b0;
    #1;
    checks++;
    if (rs1_data !== 32'h1234) begin
      errors++; $display("FAIL reset_pre_write got %h want %h", rs1_data, 32'h1234);
    end
    // Reset with a write to R6 presented in the same cycle: write is dropped.
    rst = 1'b1;
    drive_write(4'd6, 32'h55, 1'b0);
    tick();
    rst = 1'b0;
    EnRW = 1'b0;
    model_clear();
    rs2_addr = 4'd6;
    #1;
    checks++;
    if (rs1_data !== 32'h0) begin
      errors++; $display("FAIL reset_clear_r5 got %h want %h", rs1_data, 32'h0);
    end
    checks++;
    if (rs2_data !== 32'h0) begin
      errors++; $display("FAIL reset_drop_r6 got %h want %h", rs2_data, 32'h0);
    end
    checks++;
    if (wr_count !== 4'd0 || wb_commit !== 1'b0) begin
      errors++; $display("FAIL reset_clear_counters got cnt=%0d commit=%b want 0/0", wr_count, wb_commit);
    end
    // First write after reset is accepted.
    drive_write(4'd2, 32'h77, 1'b1);
    tick();
    model_write(4'd2, 32'h77);
    EnRW = 1'b0;
    rs1_addr = 4'd2;
    #1;
    checks++;
    if (rs1_data !== 32'h77 || wr_count !== 4'd1 || wb_commit !== 1'b1) begin
      errors++; $display("FAIL reset_first_write got %h cnt=%0d commit=%b want 00000077 1 1",
                         rs1_data, wr_count, wb_commit);
    end
  endtask

  task automatic test_mux_write();
    MReg = 1'b1; read_data = 32'hDEADBEEF; ALU_out = 32'h11;
    EnRW = 1'b1; reg_rd = 4'd3; rs2_addr = 4'd3;
    #1;
    checks++;
    if (wb_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL mux_sel_load got %h want %h", wb_data, 32'hDEADBEEF);
    end
    tick();
    model_write(4'd3, 32'hDEADBEEF);
    EnRW = 1'b0;
    #1;
    checks++;
    if (rs2_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL mux_load_readback got %h want %h", rs2_data, 32'hDEADBEEF);
    end
    checks++;
    if (wr_count !== 4'd2 || wb_commit !== 1'b1) begin
      errors++; $display("FAIL mux_load_counters got cnt=%0d commit=%b want 2/1", wr_count, wb_commit);
    end
    tick();
    checks++;
    if (wb_commit !== 1'b0) begin
      errors++; $display("FAIL commit_single_cycle got %b want 0", wb_commit);
    end
    // ALU path; MReg toggled with EnRW=0 must still steer wb_data.
    MReg = 1'b0; read_data = 32'hDEADBEEF; ALU_out = 32'h11;
    #1;
    checks++;
    if (wb_data !== 32'h11) begin
      errors++; $display("FAIL mux_sel_alu_idle got %h want %h", wb_data, 32'h11);
    end
    EnRW = 1'b1; reg_rd = 4'd4; rs1_addr = 4'd4;
    tick();
    model_write(4'd4, 32'h11);
    EnRW = 1'b0;
    #1;
    checks++;
    if (rs1_data !== 32'h00000011 || wr_count !== 4'd3) begin
      errors++; $display("FAIL mux_alu_readback got %h cnt=%0d want 00000011 3", rs1_data, wr_count);
    end
  endtask

  task automatic test_r0();
    drive_write(4'd0, 32'hFFFF_FFFF, 1'b0);
    rs1_addr = 4'd0;
    #1;
    checks++;
    if (rs1_data !== 32'h0) begin
      errors++; $display("FAIL r0_same_cycle got %h want %h", rs1_data, 32'h0);
    end
    tick();
    EnRW = 1'b0;
    #1;
    checks++;
    if (rs1_data !== 32'h0) begin
      errors++; $display("FAIL r0_after got %h want %h", rs1_data, 32'h0);
    end
    checks++;
    if (wr_count !== 4'd3 || wb_commit !== 1'b0) begin
      errors++; $display("FAIL r0_counters got cnt=%0d commit=%b want 3/0", wr_count, wb_commit);
    end
  endtask

  task automatic test_hazard();
    logic [DW-1:0] exp_same;
    drive_write(4'd7, 32'h1, 1'b0);
    tick();
    model_write(4'd7, 32'h1);
    drive_write(4'd7, 32'hA5A5A5A5, 1'b1);
    rs1_addr = 4'd7;
    rs2_addr = 4'd7;
    #1;
`ifdef RF_BYPASS_EN
    exp_same = 32'hA5A5A5A5;
`else
    exp_same = 32'h00000001;
`endif
    checks++;
    if (rs1_data !== exp_same) begin
      errors++; $display("FAIL hazard_same_cycle_rs1 got %h want %h", rs1_data, exp_same);
    end
    checks++;
    if (rs2_data !== exp_same) begin
      errors++; $display("FAIL hazard_same_cycle_rs2 got %h want %h", rs2_data, exp_same);
    end
    tick();
    model_write(4'd7, 32'hA5A5A5A5);
    EnRW = 1'b0;
    #1;
    checks++;
    if (rs1_data !== 32'hA5A5A5A5 || rs2_data !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL hazard_next_cycle got %h/%h want %h", rs1_data, rs2_data, 32'hA5A5A5A5);
    end
  endtask

  task automatic test_enrw_gating();
    logic [DW-1:0] exp_wb;
    for (int c = 0; c < 10; c++) begin
      EnRW      = 1'b0;
      MReg      = 1'($urandom_range(0, 1));
      read_data = $urandom;
      ALU_out   = $urandom;
      reg_rd    = 4'($urandom_range(0, 15));
      rs1_addr  = 4'($urandom_range(0, 15));
      rs2_addr  = 4'($urandom_range(0, 15));
      exp_wb    = MReg ? read_data : ALU_out;
      #1;
      checks++;
      if (wb_data !== exp_wb) begin
        errors++; $display("FAIL gating_wb_mux cycle %0d got %h want %h", c, wb_data, exp_wb);
      end
      tick();
    end
    for (int r = 0; r < 16; r++) begin
      rs1_addr = 4'(r);
      rs2_addr = 4'(15 - r);
      #1;
      checks++;
      if (rs1_data !== exp_regs[r] || rs2_data !== exp_regs[15-r]) begin
        errors++; $display("FAIL gating_regs r%0d got %h/%h want %h/%h", r, rs1_data, rs2_data,
                           exp_regs[r], exp_regs[15-r]);
      end
    end
    checks++;
    if (wr_count !== exp_cnt || wb_commit !== 1'b0) begin
      errors++; $display("FAIL gating_counters got cnt=%0d commit=%b want %0d/0", wr_count, wb_commit, exp_cnt);
    end
  endtask

  task automatic test_back_to_back_wrap();
    rst = 1'b1;
    EnRW = 1'b0;
    tick();
    rst = 1'b0;
    model_clear();
    for (int i = 0; i < 17; i++) begin
      drive_write(4'(1 + (i % 15)), 32'h100 + 32'(i), 1'(i % 2));
      tick();
      model_write(4'(1 + (i % 15)), 32'h100 + 32'(i));
    end
    EnRW = 1'b0;
    #1;
    checks++;
    if (wr_count !== 4'd1) begin
      errors++; $display("FAIL wrap_count got %0d want 1", wr_count);
    end
    checks++;
    if (wb_commit !== 1'b1) begin
      errors++; $display("FAIL wrap_commit got %b want 1", wb_commit);
    end
    rs1_addr = 4'd1; rs2_addr = 4'd2;
    #1;
    checks++;
    if (rs1_data !== 32'h10F || rs2_data !== 32'h110) begin
      errors++; $display("FAIL wrap_overwrite got %h/%h want 0000010f/00000110", rs1_data, rs2_data);
    end
    for (int r = 3; r < 16; r++) begin
      rs1_addr = 4'(r);
      #1;
      checks++;
      if (rs1_data !== exp_regs[r]) begin
        errors++; $display("FAIL wrap_reg r%0d got %h want %h", r, rs1_data, exp_regs[r]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; MReg = 1'b0; EnRW = 1'b0;
    read_data = '0; ALU_out = '0; reg_rd = '0;
    rs1_addr = '0; rs2_addr = '0;
    model_clear();
    test_reset();
    test_mux_write();
    test_r0();
    test_hazard();
    test_enrw_gating();
    test_back_to_back_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
